// File: rtl/keccak_pkg.sv
// Shared sizing and state encoding for the Keccak message path.
package keccak_pkg;

    localparam int unsigned BYTE_SIZE  = 8;
    localparam int unsigned DWIDTH     = 256;
    localparam int unsigned KEEP_WIDTH = DWIDTH / BYTE_SIZE;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_DATA  = 2'd1,
        ST_CARRY = 2'd2
    } stager_state_e;

endpackage

// File: rtl/keccak_msg_stager.sv
// Message stager: holds one upstream beat (or an absorb-stage overflow
// remainder) and presents it to the absorb stage, counting message bytes.
module keccak_msg_stager
    import keccak_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [DWIDTH-1:0]     s_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
    input  logic                  s_tlast_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    output logic [DWIDTH-1:0]     msg_o,
    output logic [KEEP_WIDTH-1:0] keep_o,
    output logic                  last_o,
    output logic                  msg_valid_o,
    input  logic                  msg_ready_i,
    input  logic                  has_carry_i,
    input  logic [DWIDTH-1:0]     carry_i,
    input  logic [KEEP_WIDTH-1:0] carry_keep_i,
    output logic [31:0]           msg_bytes_o,
    output logic                  keep_err_o
);

    function automatic logic [31:0] f_popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [31:0] c;
        c = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            c = c + 32'(k[i]);
        end
        return c;
    endfunction

    // LSB-contiguous masks are exactly those where k+1 shares no set bit with k.
    function automatic logic f_keep_contig(input logic [KEEP_WIDTH-1:0] k);
        logic [KEEP_WIDTH-1:0] kp1;
        kp1 = k + KEEP_WIDTH'(1);
        return (k & kp1) == '0;
    endfunction

    stager_state_e         r_state;
    stager_state_e         w_state_nxt;
    logic [DWIDTH-1:0]     r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_last;
    logic [31:0]           r_msg_bytes;
    logic                  r_keep_err;

    logic                  w_msg_valid;
    logic                  w_fire;
    logic                  w_tready;
    logic                  w_accept;
    logic                  w_load_beat;
    logic                  w_load_carry;
    logic                  w_msg_done;
    logic [31:0]           w_bytes_base;
    logic [32:0]           w_bytes_sum;
    logic [31:0]           w_bytes_nxt;
    logic                  w_keep_err_nxt;

    // Handshakes, next state and holding-register load selects.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_beat  = 1'b0;
        w_load_carry = 1'b0;
        w_msg_valid  = (r_state != ST_EMPTY);
        w_fire       = w_msg_valid & msg_ready_i;
        // Ready passes straight through on a carry-free fire so a new beat
        // can replace the departing one without a bubble.
        w_tready     = (r_state == ST_EMPTY) | (w_fire & ~has_carry_i);
        w_accept     = s_tvalid_i & w_tready;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_beat = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                if (w_fire) begin
                    if (has_carry_i) begin
                        w_load_carry = 1'b1;
                        w_state_nxt  = ST_CARRY;
                    end else if (w_accept) begin
                        w_load_beat = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
        endcase
        if (flush_i) begin
            w_state_nxt  = ST_EMPTY;
            w_load_beat  = 1'b0;
            w_load_carry = 1'b0;
        end
    end

    // Byte counter and non-contiguous-keep flag updates.
    always_comb begin
        w_msg_done     = w_fire & r_last & ~has_carry_i;
        w_bytes_base   = w_msg_done ? '0 : r_msg_bytes;
        w_bytes_sum    = {1'b0, w_bytes_base} + {1'b0, f_popcount(s_tkeep_i)};
        w_bytes_nxt    = w_bytes_base;
        w_keep_err_nxt = r_keep_err;
        if (w_accept) begin
            w_bytes_nxt = w_bytes_sum[32] ? '1 : w_bytes_sum[31:0];
            if (!f_keep_contig(s_tkeep_i)) begin
                w_keep_err_nxt = 1'b1;
            end
        end
        if (flush_i) begin
            w_bytes_nxt    = '0;
            w_keep_err_nxt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register: upstream beat or carry remainder (last flag retained).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
        end else if (w_load_beat) begin
            r_data <= s_tdata_i;
            r_keep <= s_tkeep_i;
            r_last <= s_tlast_i;
        end else if (w_load_carry) begin
            r_data <= carry_i;
            r_keep <= carry_keep_i;
        end
    end

    // Message byte count and sticky keep error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_bytes <= '0;
            r_keep_err  <= 1'b0;
        end else begin
            r_msg_bytes <= w_bytes_nxt;
            r_keep_err  <= w_keep_err_nxt;
        end
    end

    assign s_tready_o  = w_tready;
    assign msg_valid_o = w_msg_valid;
    assign msg_o       = r_data;
    assign keep_o      = r_keep;
    assign last_o      = r_last & w_msg_valid;
    assign msg_bytes_o = r_msg_bytes;
    assign keep_err_o  = r_keep_err;

endmodule

// File: tb/tb_keccak_msg_stager.sv
// Bench for keccak_msg_stager: SHA3-256 absorb responder plus chunk scoreboard.
module tb_keccak_msg_stager;

    localparam int unsigned RATE = 136;

    logic         clk;
    logic         rst_n;
    logic         flush_i;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready_o;
    logic [255:0] msg_o;
    logic [31:0]  keep_o;
    logic         last_o;
    logic         msg_valid_o;
    logic         msg_ready;
    logic         has_carry;
    logic [255:0] carry_d;
    logic [31:0]  carry_k;
    logic [31:0]  msg_bytes_o;
    logic         keep_err_o;

    keccak_msg_stager dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .s_tdata_i    (s_tdata),
        .s_tkeep_i    (s_tkeep),
        .s_tlast_i    (s_tlast),
        .s_tvalid_i   (s_tvalid),
        .s_tready_o   (s_tready_o),
        .msg_o        (msg_o),
        .keep_o       (keep_o),
        .last_o       (last_o),
        .msg_valid_o  (msg_valid_o),
        .msg_ready_i  (msg_ready),
        .has_carry_i  (has_carry),
        .carry_i      (carry_d),
        .carry_keep_i (carry_k),
        .msg_bytes_o  (msg_bytes_o),
        .keep_err_o   (keep_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } chunk_t;

    chunk_t      exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned abs_fill = 0;
    int unsigned mdl_fill = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned cnt(input logic [31:0] k);
        int unsigned c = 0;
        for (int i = 0; i < 32; i++) c += int'(k[i]);
        return c;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Absorb-stage responder: overflow beyond the rate becomes the carry.
    always_comb begin
        has_carry = 1'b0;
        carry_d   = '0;
        carry_k   = '0;
        if (msg_valid_o && (abs_fill + cnt(keep_o) > RATE)) begin
            has_carry = 1'b1;
            carry_d   = msg_o >> ((RATE - abs_fill) * 8);
            carry_k   = keep_o >> (RATE - abs_fill);
        end
    end

    // Expected chunk stream derived from the accepted beats.
    task automatic push_exp(input logic [255:0] d, input logic [31:0] k, input logic l);
        int unsigned n  = cnt(k);
        int unsigned sp = RATE - mdl_fill;
        chunk_t c;
        c.d = d; c.k = k; c.l = l;
        exp_q.push_back(c);
        if (mdl_fill + n > RATE) begin
            c.d = d >> (sp * 8);
            c.k = k >> sp;
            exp_q.push_back(c);
            mdl_fill = l ? 0 : n - sp;
        end else begin
            mdl_fill = l ? 0 : (mdl_fill + n) % RATE;
        end
    endtask

    // Output monitor: compare every fired chunk, then advance the absorb fill.
    logic        mon_fired;
    logic        mon_hc;
    logic        mon_last;
    int unsigned mon_n;
    always begin
        @(negedge clk);
        mon_fired = 1'b0;
        if (rst_n && msg_valid_o && msg_ready) begin
            mon_fired = 1'b1;
            mon_hc    = has_carry;
            mon_last  = last_o;
            mon_n     = cnt(keep_o);
            chk("chunk_expected", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                chunk_t e;
                e = exp_q.pop_front();
                chk("chunk_data", msg_o, e.d);
                chk("chunk_keep", 256'(keep_o), 256'(e.k));
                chk("chunk_last", 256'(last_o), 256'(e.l));
            end
        end
        @(posedge clk);
        #1;
        if (mon_fired) abs_fill = (mon_hc || mon_last) ? 0 : (abs_fill + mon_n) % RATE;
    end

    task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l, output int waits);
        logic ok = 1'b0;
        int   w  = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!ok && w < 100) begin
            @(negedge clk);
            if (s_tready_o) ok = 1'b1;
            else w++;
        end
        chk("accept", 256'(ok), 256'(1));
        if (ok && !flush_i) push_exp(d, k, l);
        @(posedge clk);
        #1;
        waits = w;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
    endtask

    task automatic send5();
        int w;
        for (int i = 0; i < 5; i++) begin
            send(rand256(), 32'hFFFF_FFFF, (i == 4), w);
            chk("beat_no_bubble", 256'(w), 256'(0));
        end
        idle();
    endtask

    task automatic clear_sb();
        exp_q.delete();
        abs_fill = 0;
        mdl_fill = 0;
    endtask

    initial begin
        int           w;
        logic [255:0] d1;
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = 1'b0;
        s_tvalid  = 1'b0;
        msg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 256'(msg_valid_o), 256'(0));
        chk("rst_last", 256'(last_o), 256'(0));
        chk("rst_msg", msg_o, '0);
        chk("rst_keep", 256'(keep_o), 256'(0));
        chk("rst_bytes", 256'(msg_bytes_o), 256'(0));
        chk("rst_keep_err", 256'(keep_err_o), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tready", 256'(s_tready_o), 256'(1));
        @(posedge clk);
        #1;

        // Five full beats at rate 1088: fifth beat overflows by 24 bytes.
        send5();
        @(negedge clk);
        chk("bytes_160", 256'(msg_bytes_o), 256'(160));
        chk("carry_fire_tready", 256'(s_tready_o), 256'(0));
        @(negedge clk);
        chk("carry_keep", 256'(keep_o), 256'(32'h00FF_FFFF));
        chk("carry_last", 256'(last_o), 256'(1));
        chk("carry_tready", 256'(s_tready_o), 256'(1));
        chk("carry_bytes", 256'(msg_bytes_o), 256'(160));
        @(negedge clk);
        chk("msg_end_bytes", 256'(msg_bytes_o), 256'(0));
        chk("msg_end_valid", 256'(msg_valid_o), 256'(0));
        @(posedge clk);
        #1;

        // Single 4-byte final beat held, then released.
        msg_ready = 1'b0;
        send(rand256(), 32'h0000_000F, 1'b1, w);
        idle();
        @(negedge clk);
        chk("bytes_4", 256'(msg_bytes_o), 256'(4));
        @(posedge clk);
        #1;
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bytes_4_cleared", 256'(msg_bytes_o), 256'(0));
        @(posedge clk);
        #1;

        // New message accepted in the cycle the previous one completes.
        send(rand256(), 32'h0000_000F, 1'b1, w);
        send(rand256(), 32'h0000_00FF, 1'b1, w);
        idle();
        @(negedge clk);
        chk("bytes_restart", 256'(msg_bytes_o), 256'(8));
        @(posedge clk);
        #1;

        // Empty final chunk is forwarded.
        send('0, 32'h0, 1'b1, w);
        idle();
        @(negedge clk);
        chk("empty_last_bytes", 256'(msg_bytes_o), 256'(0));
        @(posedge clk);
        #1;

        // Keep contiguity flag.
        send(rand256(), 32'h0000_000F, 1'b1, w);
        idle();
        @(negedge clk);
        chk("keep_err_contig", 256'(keep_err_o), 256'(0));
        @(posedge clk);
        #1;
        send(rand256(), 32'h0000_000A, 1'b0, w);
        send(rand256(), 32'h0000_00FF, 1'b1, w);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("keep_err_sticky", 256'(keep_err_o), 256'(1));
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("keep_err_flushed", 256'(keep_err_o), 256'(0));
        @(posedge clk);
        #1;

        // Downstream stall for 10 cycles with a second beat waiting.
        msg_ready = 1'b0;
        d1 = rand256();
        send(d1, 32'hFFFF_FFFF, 1'b0, w);
        s_tdata  = rand256();
        s_tkeep  = 32'hFFFF_FFFF;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_msg", msg_o, d1);
            chk("stall_tready", 256'(s_tready_o), 256'(0));
        end
        @(posedge clk);
        #1;
        msg_ready = 1'b1;
        send(s_tdata, 32'hFFFF_FFFF, 1'b1, w);
        chk("stall_release_wait", 256'(w), 256'(0));
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Flush while holding the carry, with a beat offered.
        send5();
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
        flush_i   = 1'b1;
        s_tdata   = rand256();
        s_tkeep   = 32'hFFFF_FFFF;
        s_tvalid  = 1'b1;
        @(negedge clk);
        chk("pre_flush_carry", 256'(keep_o), 256'(32'h00FF_FFFF));
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_valid", 256'(msg_valid_o), 256'(0));
        chk("flush_tready", 256'(s_tready_o), 256'(1));
        chk("flush_bytes", 256'(msg_bytes_o), 256'(0));
        clear_sb();
        msg_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_dropped", 256'(msg_valid_o), 256'(0));
        @(posedge clk);
        #1;

        // Same scenario with an asynchronous reset pulse.
        send5();
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
        s_tdata   = rand256();
        s_tkeep   = 32'hFFFF_FFFF;
        s_tvalid  = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("areset_valid", 256'(msg_valid_o), 256'(0));
        chk("areset_keep", 256'(keep_o), 256'(0));
        chk("areset_bytes", 256'(msg_bytes_o), 256'(0));
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        clear_sb();
        msg_ready = 1'b1;
        @(negedge clk);
        chk("areset_tready", 256'(s_tready_o), 256'(1));
        repeat (3) @(negedge clk);
        chk("areset_dropped", 256'(msg_valid_o), 256'(0));

        // Final short message, then drain.
        @(posedge clk);
        #1;
        send(rand256(), 32'h0000_FFFF, 1'b0, w);
        send(rand256(), 32'h0000_0003, 1'b1, w);
        idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
